// File: rtl/pump_pkg.sv
// Shared types and constants for the duplex pump scheduler.
package pump_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DWELL = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic PUMP_B1 = 1'b0;
    localparam logic PUMP_B2 = 1'b1;
    localparam int   CNT_W   = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pump_timer.sv
// Tick-qualified saturating up-counter; clear has priority over tick.
module pump_timer
    import pump_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pump_sched.sv
// Duplex sump pump scheduler with alternation, failover and cool-down dwell.
// PUMP_SCHED_BOOST_EN: lvl_hh brings in the idle healthy pump alongside the lead pump.
//   state | meaning
//   IDLE  | waiting for lvl_high demand
//   RUN   | lead pump running, counter holds ticks since run start
//   DWELL | all pumps off, counter holds cool-down ticks
//   FAULT | no healthy pump, alarm raised
module pump_sched
    import pump_pkg::*;
#(
    parameter int MIN_RUN = 8,
    parameter int COOL    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       lvl_low,
    input  logic       lvl_high,
    input  logic       lvl_hh,
    input  logic       flt_b1,
    input  logic       flt_b2,
    output logic       run_b1,
    output logic       run_b2,
    output logic       last_b2,
    output logic       alarm,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] C_MIN_RUN = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] C_COOL_M1 = CNT_W'(COOL - 1);

    state_t           r_state;
    logic             r_active;
    logic             r_run_b1;
    logic             r_run_b2;
    logic             r_last_b2;
    logic             r_alarm;

    logic [CNT_W-1:0] w_count;
    logic             w_clr;
    logic             w_run_done;
    logic             w_cool_done;
    logic             w_act_flt;
    logic             w_oth_flt;
    logic             w_pick;
    logic             w_boost;

    assign w_act_flt   = (r_active == PUMP_B2) ? flt_b2 : flt_b1;
    assign w_oth_flt   = (r_active == PUMP_B2) ? flt_b1 : flt_b2;
    assign w_run_done  = !lvl_low && (w_count >= C_MIN_RUN);
    assign w_cool_done = tick && (w_count >= C_COOL_M1);

    // Alternate when both are healthy, otherwise take whichever one is left.
    assign w_pick = flt_b1 ? PUMP_B2 :
                    flt_b2 ? PUMP_B1 :
                    (r_last_b2 ? PUMP_B1 : PUMP_B2);

    // Held clear outside RUN/DWELL so it reads zero on entry to either.
    assign w_clr = (r_state == S_IDLE) || (r_state == S_FAULT) ||
                   ((r_state == S_RUN) && w_run_done);

`ifdef PUMP_SCHED_BOOST_EN
    assign w_boost = lvl_hh && !w_oth_flt;
`else
    logic w_unused_hh;
    assign w_unused_hh = lvl_hh;
    assign w_boost     = 1'b0;
`endif

    pump_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (w_clr),
        .tick  (tick),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_active  <= PUMP_B1;
            r_run_b1  <= 1'b0;
            r_run_b2  <= 1'b0;
            r_last_b2 <= 1'b1;
            r_alarm   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lvl_high) begin
                        if (flt_b1 && flt_b2) begin
                            r_state <= S_FAULT;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_active <= w_pick;
                            r_run_b1 <= (w_pick == PUMP_B1);
                            r_run_b2 <= (w_pick == PUMP_B2);
                        end
                    end
                end
                S_RUN: begin
                    if (w_run_done) begin
                        r_state   <= S_DWELL;
                        r_last_b2 <= r_active;
                        r_run_b1  <= 1'b0;
                        r_run_b2  <= 1'b0;
                    end else if (w_act_flt) begin
                        if (!w_oth_flt) begin
                            r_active <= ~r_active;
                            r_run_b1 <= (r_active == PUMP_B2);
                            r_run_b2 <= (r_active == PUMP_B1);
                        end else begin
                            r_state  <= S_FAULT;
                            r_alarm  <= 1'b1;
                            r_run_b1 <= 1'b0;
                            r_run_b2 <= 1'b0;
                        end
                    end else begin
                        r_run_b1 <= (r_active == PUMP_B1) || w_boost;
                        r_run_b2 <= (r_active == PUMP_B2) || w_boost;
                    end
                end
                S_DWELL: begin
                    if (w_cool_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (!flt_b1 || !flt_b2) begin
                        r_state <= S_IDLE;
                        r_alarm <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_run_b1 <= 1'b0;
                    r_run_b2 <= 1'b0;
                    r_alarm  <= 1'b0;
                end
            endcase
        end
    end

    assign run_b1  = r_run_b1;
    assign run_b2  = r_run_b2;
    assign last_b2 = r_last_b2;
    assign alarm   = r_alarm;
    assign state   = r_state;

endmodule

// File: tb/tb_pump_sched.sv
// Directed scoreboard bench for pump_sched (MIN_RUN=8, COOL=4).
module tb_pump_sched;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tick     = 1'b0;
    logic       lvl_low  = 1'b0;
    logic       lvl_high = 1'b0;
    logic       lvl_hh   = 1'b0;
    logic       flt_b1   = 1'b0;
    logic       flt_b2   = 1'b0;
    logic       run_b1;
    logic       run_b2;
    logic       last_b2;
    logic       alarm;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pump_sched #(.MIN_RUN(8), .COOL(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .lvl_low  (lvl_low),
        .lvl_high (lvl_high),
        .lvl_hh   (lvl_hh),
        .flt_b1   (flt_b1),
        .flt_b2   (flt_b2),
        .run_b1   (run_b1),
        .run_b2   (run_b2),
        .last_b2  (last_b2),
        .alarm    (alarm),
        .state    (state)
    );

    // Expected vector layout: {state[1:0], run_b1, run_b2, last_b2, alarm}
    task automatic sb_push(input string tag, input logic [1:0] st, input logic r1,
                           input logic r2, input logic lb2, input logic al);
        exp_t e;
        e.tag = tag;
        e.v   = {st, r1, r2, lb2, al};
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t       e;
        logic [5:0] obs;
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: no expectation queued");
        end else begin
            e   = sb.pop_front();
            obs = {state, run_b1, run_b2, last_b2, alarm};
            assert (obs === e.v) n_pass++;
            else $error("FAIL %s: observed st/b1/b2/last/alarm=%b required %b", e.tag, obs, e.v);
        end
    endtask

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        sb_push("reset_async", 2'd0, 0, 0, 1, 0); sb_check();
        @(negedge clk);
        reset = 1'b1; lvl_low = 1'b1; lvl_high = 1'b1;

        sb_push("run_b1_first", 2'd1, 1, 0, 1, 0); step(0); sb_check();
        lvl_high = 1'b0;
        repeat (10) step(1);
        sb_push("run_b1_hold", 2'd1, 1, 0, 1, 0); sb_check();
        lvl_low = 1'b0; lvl_high = 1'b1;
        sb_push("dwell_entry", 2'd2, 0, 0, 0, 0); step(0); sb_check();
        repeat (3) step(1);
        sb_push("dwell_defer", 2'd2, 0, 0, 0, 0); sb_check();
        sb_push("idle_after_cool", 2'd0, 0, 0, 0, 0); step(1); sb_check();

        sb_push("run_b2_alt", 2'd1, 0, 1, 0, 0); step(0); sb_check();
        lvl_high = 1'b0;
        repeat (8) step(1);
        sb_push("min_run_hold_b2", 2'd1, 0, 1, 0, 0); sb_check();
        sb_push("dwell_b2", 2'd2, 0, 0, 1, 0); step(0); sb_check();
        repeat (4) step(1);
        sb_push("idle2", 2'd0, 0, 0, 1, 0); sb_check();

        lvl_high = 1'b1; lvl_low = 1'b1;
        sb_push("run_b1_third", 2'd1, 1, 0, 1, 0); step(0); sb_check();
        lvl_high = 1'b0;
        repeat (3) step(1);
        lvl_low = 1'b0;
        repeat (6) step(0);
        sb_push("no_tick_no_count", 2'd1, 1, 0, 1, 0); sb_check();
        repeat (5) step(1);
        sb_push("min_run_tick8", 2'd1, 1, 0, 1, 0); sb_check();
        sb_push("dwell_third", 2'd2, 0, 0, 0, 0); step(0); sb_check();
        repeat (4) step(1);

        lvl_high = 1'b1; lvl_low = 1'b1;
        sb_push("run_b2_pre_reset", 2'd1, 0, 1, 0, 0); step(0); sb_check();
        lvl_high = 1'b0;
        step(1);
        #2 reset = 1'b0;
        #1;
        sb_push("reset_mid_run", 2'd0, 0, 0, 1, 0); sb_check();
        #1 reset = 1'b1;

        lvl_high = 1'b1;
        sb_push("run_b1_post_reset", 2'd1, 1, 0, 1, 0); step(0); sb_check();
        lvl_high = 1'b0;
        repeat (2) step(1);
        flt_b1 = 1'b1;
        sb_push("failover_b2", 2'd1, 0, 1, 1, 0); step(0); sb_check();
        flt_b2 = 1'b1;
        sb_push("fault_both", 2'd3, 0, 0, 1, 1); step(0); sb_check();
        sb_push("fault_hold", 2'd3, 0, 0, 1, 1); step(1); sb_check();
        flt_b1 = 1'b0;
        sb_push("fault_clear", 2'd0, 0, 0, 1, 0); step(0); sb_check();
        flt_b2 = 1'b0;

        lvl_high = 1'b1;
        sb_push("run_b1_sim", 2'd1, 1, 0, 1, 0); step(0); sb_check();
        lvl_high = 1'b0;
        repeat (8) step(1);
        lvl_low = 1'b0; flt_b1 = 1'b1;
        sb_push("sim_low_fault_dwell", 2'd2, 0, 0, 0, 0); step(0); sb_check();
        flt_b1 = 1'b0; lvl_low = 1'b1;
        repeat (4) step(1);

        flt_b1 = 1'b1; flt_b2 = 1'b1; lvl_high = 1'b1;
        sb_push("idle_both_flt", 2'd3, 0, 0, 0, 1); step(0); sb_check();
        flt_b1 = 1'b0;
        sb_push("fault_exit", 2'd0, 0, 0, 0, 0); step(0); sb_check();
        sb_push("single_healthy_b1", 2'd1, 1, 0, 0, 0); step(0); sb_check();
        lvl_high = 1'b0; flt_b2 = 1'b0;

        lvl_hh = 1'b1;
`ifdef PUMP_SCHED_BOOST_EN
        sb_push("boost_on", 2'd1, 1, 1, 0, 0);
`else
        sb_push("boost_ignored", 2'd1, 1, 0, 0, 0);
`endif
        step(0); sb_check();
        lvl_hh = 1'b0;
        sb_push("boost_drop", 2'd1, 1, 0, 0, 0); step(0); sb_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pump_sched.md
PUMP_SCHED -- requirements
Module: pump_sched

Interface
- REQ-001 SHALL have parameter MIN_RUN, default 8: minimum RUN duration in ticks, range 1..255.
- REQ-002 SHALL have parameter COOL, default 4: all-off dwell after a run in ticks, range 1..255.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port tick, input, 1: one-clk timebase strobe; timers advance only on cycles with tick=1.
- REQ-006 SHALL have port lvl_low, input, 1: level above low float switch.
- REQ-007 SHALL have port lvl_high, input, 1: level above high float switch (pumping demand).
- REQ-008 SHALL have port lvl_hh, input, 1: high-high level; ignored unless PUMP_SCHED_BOOST_EN is defined.
- REQ-009 SHALL have ports flt_b1 and flt_b2, input, 1 each: pump B1/B2 faulted.
- REQ-010 SHALL have ports run_b1 and run_b2, output, 1 each: pump B1/B2 run command, registered.
- REQ-011 SHALL have port last_b2, output, 1: 1 = B2 was the last pump to complete a run.
- REQ-012 SHALL have port alarm, output, 1: 1 while in FAULT.
- REQ-013 SHALL have port state, output, 2: current state encoding.

Function
- REQ-014 SHALL implement states IDLE=0, RUN=1, DWELL=2, FAULT=3.
- REQ-015 IDLE: lvl_high=1 -> RUN with the healthy pump opposite last_b2; if only one pump is healthy, use it; if both are faulted -> FAULT.
- REQ-016 The run output SHALL assert on the first clk edge after lvl_high=1 is sampled in IDLE (1-cycle latency).
- REQ-017 RUN SHALL assert exactly one of run_b1/run_b2 (boost excepted); the run counter clears on RUN entry and increments on each tick, saturating at 255.
- REQ-018 RUN -> DWELL when lvl_low=0 and count >= MIN_RUN; last_b2 updates to the active pump on that same edge.
- REQ-019 If lvl_low=0 before MIN_RUN elapses, the pump SHALL keep running until count reaches MIN_RUN.
- REQ-020 Active-pump fault in RUN: switch to the other pump on the next edge if it is healthy (counter not cleared, last_b2 unchanged); otherwise -> FAULT. Both outputs are 0 during that edge's cycle only if no healthy pump exists.
- REQ-021 DWELL: all run outputs 0; the counter counts COOL ticks, then -> IDLE; lvl_high during DWELL is deferred until IDLE.
- REQ-022 FAULT: run outputs 0, alarm=1; -> IDLE when either flt_* is deasserted.
- REQ-023 Simultaneous lvl_low=0 (with count >= MIN_RUN) and active-pump fault SHALL resolve to DWELL.
- REQ-024 The block SHALL never assert run_bX while flt_bX=1 for more than one clk.

Reset
- REQ-025 On reset=0 the block SHALL set state=IDLE, run_b1=run_b2=0, alarm=0, last_b2=1 (B1 is served first), and counter=0, all immediately (asynchronously).
- REQ-026 A reset asserted mid-RUN SHALL drop the run outputs asynchronously; after release the block evaluates from IDLE.

Configuration
- REQ-027 With PUMP_SCHED_BOOST_EN defined: in RUN, lvl_hh=1 SHALL additionally assert the idle healthy pump; that boost drops when lvl_hh=0 or on RUN exit, and last_b2 is unaffected by the boost.
- REQ-028 Without PUMP_SCHED_BOOST_EN: the lvl_hh port SHALL exist but be ignored, and at most one run output is ever 1.

Structure
- REQ-029 Package pump_pkg SHALL hold the state enum, pump-id constants (PUMP_B1=0, PUMP_B2=1) and the counter width constant (8).
- REQ-030 The tick-qualified saturating counter SHALL be the sub-module pump_timer (clear, tick, count).

Verification
- REQ-031 Reset, then lvl_high=1 -> run_b1=1 after 1 clk; hold lvl_low=1 for 10 ticks, then lvl_low=0 -> DWELL, last_b2=0, 4 ticks later IDLE.
- REQ-032 Second demand -> run_b2=1 (alternation); third demand -> run_b1=1.
- REQ-033 lvl_low=0 at tick 3 with MIN_RUN=8 -> pump stays on until tick 8, then DWELL.
- REQ-034 flt_b1=1 during B1 run -> run_b1=0, run_b2=1 next clk; then flt_b2=1 -> FAULT, alarm=1; clear flt_b1 -> IDLE.
- REQ-035 Boost build, B1 running, lvl_hh=1 -> run_b1=run_b2=1; lvl_hh=0 -> run_b2=0; non-boost build: run_b2 stays 0.
- REQ-036 reset=0 mid-RUN between clk edges -> run outputs 0 immediately, state=IDLE, last_b2=1.
